// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR frame decoder:
//   - ir_state_t : decoder FSM states
//   - ERR_*      : err_code values reported on a rejected frame
//   - clog2()    : ceiling log2, used to size counters from parameters
// ---------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CUSTOM,
    ST_DATA,
    ST_DATA_INV,
    ST_STOP,
    ST_GAP
  } ir_state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_INV    = 2'd1;
  localparam logic [1:0] ERR_REJECT = 2'd2;
  localparam logic [1:0] ERR_STOP   = 2'd3;

  // Smallest r with 2**r >= value (value >= 2 everywhere it is used).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_bit_sampler.sv
// ---------------------------------------------------------------------------
// ir_bit_sampler
// Synchronises the raw IR line and generates the bit-timing strobes used by
// the frame FSM.
//   clk, rst       : clock, asynchronous active-high reset
//   serial         : raw IR line (idle high, asynchronous to clk)
//   start_phase    : FSM is confirming a start bit
//   bit_phase      : FSM is receiving field or stop bits
//   s              : synchronised line value
//   start_ok       : start bit still low at its half-bit check point
//   start_glitch   : line back high at the half-bit check point
//   sample_strobe  : mid-bit sample point during bit_phase
// ---------------------------------------------------------------------------
module ir_bit_sampler
  import ir_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic serial,
  input  logic start_phase,
  input  logic bit_phase,
  output logic s,
  output logic start_ok,
  output logic start_glitch,
  output logic sample_strobe
);

  localparam int CW   = clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;

  // Synchroniser flops come out of reset at the idle line level so that
  // reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], serial};
    end
  end

  assign s = sync_reg[1];

  // The counter is held at zero outside the start/bit phases, so every
  // phase begins counting from 0. After the half-bit start check it wraps
  // to 0, which places each later wrap at the centre of a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (bit_phase) begin
      cnt_reg <= (cnt_reg == LAST_CNT) ? '0 : cnt_reg + CW'(1);
    end else if (start_phase) begin
      cnt_reg <= (cnt_reg == HALF_CNT) ? '0 : cnt_reg + CW'(1);
    end else begin
      cnt_reg <= '0;
    end
  end

  assign start_ok      = start_phase && (cnt_reg == HALF_CNT) && !s;
  assign start_glitch  = start_phase && (cnt_reg == HALF_CNT) &&  s;
  assign sample_strobe = bit_phase   && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/ir_frame_decoder.sv
// ---------------------------------------------------------------------------
// ir_frame_decoder
// Decodes start / custom / data / inverted-data / stop IR frames (MSB first,
// oversampled) and presents the key on a valid/ack handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   serial    : raw IR line, idle high
//   ack       : consumer takes the key (only meaningful while valid=1)
//   key       : decoded data field, all ones when empty
//   custom    : custom field of the frame held in key
//   valid     : key/custom hold an unaccepted frame
//   overrun   : sticky, a good frame was dropped while valid=1
//   err       : one-cycle pulse on a rejected frame
//   err_code  : cause of the last rejection (see ERR_* in ir_pkg)
// Field widths must be at least 2 bits.
// ---------------------------------------------------------------------------
module ir_frame_decoder
  import ir_pkg::*;
#(
  parameter int                  CUSTOM_W     = 16,
  parameter int                  DATA_W       = 8,
  parameter int                  CLKS_PER_BIT = 4,
  parameter int                  CHECK_CUSTOM = 0,
  parameter logic [CUSTOM_W-1:0] CUSTOM_CODE  = '0,
  parameter int                  KEY_MAX      = 2**DATA_W - 1,
  parameter int                  GAP_BITS     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial,
  input  logic                ack,
  output logic [DATA_W-1:0]   key,
  output logic [CUSTOM_W-1:0] custom,
  output logic                valid,
  output logic                overrun,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int MAX_W   = (CUSTOM_W > DATA_W) ? CUSTOM_W : DATA_W;
  localparam int BW      = clog2(MAX_W + 1);
  localparam int GAP_LEN = GAP_BITS * CLKS_PER_BIT;
  localparam int GW      = clog2(GAP_LEN + 1);
  localparam logic [BW-1:0] CUSTOM_LAST = BW'(CUSTOM_W - 1);
  localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_LEN - 1);

  ir_state_t state_reg, state_next;

  logic [BW-1:0]       bit_cnt_reg;
  logic [GW-1:0]       gap_cnt_reg;
  logic [CUSTOM_W-1:0] custom_sr_reg;
  logic [DATA_W-1:0]   data_sr_reg;
  logic [DATA_W-1:0]   inv_sr_reg;

  logic [DATA_W-1:0]   key_reg;
  logic [CUSTOM_W-1:0] custom_reg;
  logic                valid_reg;
  logic                overrun_reg;
  logic                err_reg;
  logic [1:0]          err_code_reg;

  logic s, start_ok, start_glitch, sample_strobe;
  logic start_phase, bit_phase;
  logic field_last, frame_done, key_too_big;
  logic [1:0] frame_code;

  assign start_phase = (state_reg == ST_START);
  assign bit_phase   = (state_reg == ST_CUSTOM) || (state_reg == ST_DATA) ||
                       (state_reg == ST_DATA_INV) || (state_reg == ST_STOP);

  ir_bit_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .serial        (serial),
    .start_phase   (start_phase),
    .bit_phase     (bit_phase),
    .s             (s),
    .start_ok      (start_ok),
    .start_glitch  (start_glitch),
    .sample_strobe (sample_strobe)
  );

  // Last bit of the field currently being shifted in.
  always_comb begin
    field_last = 1'b0;
    case (state_reg)
      ST_CUSTOM:   field_last = (bit_cnt_reg == CUSTOM_LAST);
      ST_DATA,
      ST_DATA_INV: field_last = (bit_cnt_reg == DATA_LAST);
      default:     field_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (!s) state_next = ST_START;
      ST_START: begin
        if (start_ok)          state_next = ST_CUSTOM;
        else if (start_glitch) state_next = ST_IDLE;
      end
      ST_CUSTOM:   if (sample_strobe && field_last) state_next = ST_DATA;
      ST_DATA:     if (sample_strobe && field_last) state_next = ST_DATA_INV;
      ST_DATA_INV: if (sample_strobe && field_last) state_next = ST_STOP;
      ST_STOP:     if (sample_strobe) state_next = ST_GAP;
      // Re-arm only after an unbroken run of idle-high line.
      ST_GAP:      if (s && (gap_cnt_reg == GAP_LAST)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Bit counter, gap counter and field shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      custom_sr_reg <= '0;
      data_sr_reg   <= '0;
      inv_sr_reg    <= '0;
    end else begin
      gap_cnt_reg <= '0;
      case (state_reg)
        ST_CUSTOM, ST_DATA, ST_DATA_INV: begin
          if (sample_strobe) begin
            bit_cnt_reg <= field_last ? '0 : bit_cnt_reg + BW'(1);
            if (state_reg == ST_CUSTOM)
              custom_sr_reg <= {custom_sr_reg[CUSTOM_W-2:0], s};
            else if (state_reg == ST_DATA)
              data_sr_reg <= {data_sr_reg[DATA_W-2:0], s};
            else
              inv_sr_reg <= {inv_sr_reg[DATA_W-2:0], s};
          end
        end
        ST_STOP: ;
        ST_GAP:  gap_cnt_reg <= s ? gap_cnt_reg + GW'(1) : '0;
        default: bit_cnt_reg <= '0;
      endcase
    end
  end

  // Frame verdict at the stop-bit sample, highest-priority cause first.
  assign frame_done  = (state_reg == ST_STOP) && sample_strobe;
  assign key_too_big = 32'(data_sr_reg) > KEY_MAX;

  always_comb begin
    frame_code = ERR_NONE;
    if (!s)
      frame_code = ERR_STOP;
    else if ((data_sr_reg ^ inv_sr_reg) != {DATA_W{1'b1}})
      frame_code = ERR_INV;
    else if (((CHECK_CUSTOM != 0) && (custom_sr_reg != CUSTOM_CODE)) || key_too_big)
      frame_code = ERR_REJECT;
  end

  // Output holding registers and handshake. A good frame arriving together
  // with ack replaces the accepted key directly, so valid never drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg      <= '1;
      custom_reg   <= '0;
      valid_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      err_reg <= 1'b0;
      if (valid_reg && ack) begin
        valid_reg   <= 1'b0;
        key_reg     <= '1;
        overrun_reg <= 1'b0;
      end
      if (frame_done) begin
        if (frame_code != ERR_NONE) begin
          err_reg      <= 1'b1;
          err_code_reg <= frame_code;
        end else if (!valid_reg || ack) begin
          key_reg    <= data_sr_reg;
          custom_reg <= custom_sr_reg;
          valid_reg  <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end
    end
  end

  assign key      = key_reg;
  assign custom   = custom_reg;
  assign valid    = valid_reg;
  assign overrun  = overrun_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

endmodule

// File: tb/tb_ir_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_ir_frame_decoder
// Drives whole IR frames onto serial and compares the decoder outputs with a
// frame-level model of the expected handshake state. The DUT is built with
// custom checking on (code 0x00FF) and KEY_MAX = 0x1F.
// ---------------------------------------------------------------------------
module tb_ir_frame_decoder;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial;
  logic        ack;
  logic [7:0]  key;
  logic [15:0] custom;
  logic        valid;
  logic        overrun;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int fails  = 0;
  int err_pulses = 0;

  // Model of the observable decoder state.
  logic        m_valid;
  logic [7:0]  m_key;
  logic [15:0] m_custom;
  logic        m_overrun;
  logic [1:0]  m_err_code;
  int          m_errs = 0;

  ir_frame_decoder #(
    .CUSTOM_W     (16),
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB),
    .CHECK_CUSTOM (1),
    .CUSTOM_CODE  (16'h00FF),
    .KEY_MAX      ('h1F),
    .GAP_BITS     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial   (serial),
    .ack      (ack),
    .key      (key),
    .custom   (custom),
    .valid    (valid),
    .overrun  (overrun),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_key      = 8'hFF;
    m_custom   = 16'h0000;
    m_overrun  = 1'b0;
    m_err_code = 2'd0;
  endtask

  task automatic chk_outputs(input string tag);
    $display("check %s: key=%0h custom=%0h valid=%0b overrun=%0b err_code=%0d",
             tag, key, custom, valid, overrun, err_code);
    chk({tag, ".key"},      32'(key),      32'(m_key));
    chk({tag, ".custom"},   32'(custom),   32'(m_custom));
    chk({tag, ".valid"},    32'(valid),    32'(m_valid));
    chk({tag, ".overrun"},  32'(overrun),  32'(m_overrun));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_err_code));
  endtask

  // Expected rejection cause of a frame, straight from the frame rules.
  function automatic logic [1:0] classify(input logic [15:0] cu, input logic [7:0] d,
                                          input logic [7:0] di, input logic st);
    if (!st) return 2'd3;
    if ((d ^ di) != 8'hFF) return 2'd1;
    if (cu != 16'h00FF || d > 8'h1F) return 2'd2;
    return 2'd0;
  endfunction

  // Sends one frame starting just after a clock edge. ack_ld raises ack in
  // the cycle the frame completes; idle is the number of high cycles after
  // the stop bit before returning.
  task automatic send_frame(input logic [15:0] cu, input logic [7:0] d, input logic [7:0] di,
                            input logic st, input bit ack_ld, input int idle);
    logic [31:0] bits;
    logic [1:0]  code;
    logic        v0;
    bits = {cu, d, di};
    serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 31; i >= 0; i--) begin
      serial = bits[i];
      repeat (CPB) tick();
    end
    serial = st;
    repeat (CPB) tick();
    // One cycle before the expected result: nothing changed yet.
    chk("pre.valid", 32'(valid), 32'(m_valid));
    chk("pre.err",   32'(err),   32'(0));
    v0     = m_valid;
    code   = classify(cu, d, di, st);
    ack    = ack_ld;
    serial = 1'b1;
    tick();
    ack = 1'b0;
    if (ack_ld && v0) begin
      m_valid   = 1'b0;
      m_key     = 8'hFF;
      m_overrun = 1'b0;
    end
    if (code != 2'd0) begin
      m_err_code = code;
      m_errs++;
    end else if (!v0 || ack_ld) begin
      m_key    = d;
      m_custom = cu;
      m_valid  = 1'b1;
    end else begin
      m_overrun = 1'b1;
    end
    $display("frame custom=%0h data=%0h inv=%0h stop=%0b ack=%0b -> code %0d",
             cu, d, di, st, ack_ld, code);
    chk("frame.err", 32'(err), 32'(code != 2'd0));
    chk_outputs("frame");
    tick();
    chk("err.width", 32'(err), 32'(0));
    repeat (idle - 2) tick();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (m_valid) begin
      m_valid   = 1'b0;
      m_key     = 8'hFF;
      m_overrun = 1'b0;
    end
    chk_outputs("ack");
  endtask

  initial begin
    logic [15:0] cu;
    logic [7:0]  d, di;
    logic        st;
    bit          ackl;

    rst = 1'b1;
    serial = 1'b1;
    ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    chk("reset.err", 32'(err), 32'(0));
    rst = 1'b0;
    repeat (3) tick();

    // Basic good frame, then ack.
    send_frame(16'h00FF, 8'h12, 8'hED, 1'b1, 1'b0, 14);
    ack_pulse();

    // Inverse mismatch, then a good frame after a 12-cycle gap.
    send_frame(16'h00FF, 8'h12, 8'hEC, 1'b1, 1'b0, 12);
    send_frame(16'h00FF, 8'h12, 8'hED, 1'b1, 1'b0, 14);
    ack_pulse();

    // One-cycle low glitch on the idle line.
    begin
      int e0;
      e0 = err_pulses;
      serial = 1'b0;
      tick();
      serial = 1'b1;
      repeat (8) tick();
      chk("glitch.err", 32'(err_pulses), 32'(e0));
      chk("glitch.valid", 32'(valid), 32'(m_valid));
    end
    send_frame(16'h00FF, 8'h03, 8'hFC, 1'b1, 1'b0, 14);
    ack_pulse();

    // Overrun, then back-to-back accept.
    send_frame(16'h00FF, 8'h05, 8'hFA, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h07, 8'hF8, 1'b1, 1'b0, 14);
    ack_pulse();
    send_frame(16'h00FF, 8'h05, 8'hFA, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h07, 8'hF8, 1'b1, 1'b1, 14);
    ack_pulse();

    // Custom mismatch and key range rejects; key 0x1F is the last accepted.
    send_frame(16'h10EF, 8'h12, 8'hED, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h20, 8'hDF, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h1F, 8'hE0, 1'b1, 1'b0, 14);
    ack_pulse();

    // Reset in the middle of the data field with live output state.
    send_frame(16'h00FF, 8'h09, 8'hF6, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h0A, 8'hF6, 1'b1, 1'b0, 14);
    send_frame(16'h00FF, 8'h0B, 8'hF4, 1'b1, 1'b0, 14);
    begin
      logic [31:0] bits;
      bits = {16'h00FF, 8'h11, 8'hEE};
      serial = 1'b0;
      repeat (CPB) tick();
      for (int i = 31; i >= 12; i--) begin
        serial = bits[i];
        repeat (CPB) tick();
      end
      serial = 1'b1;
      rst = 1'b1;
      #1;
      model_reset();
      chk_outputs("midrst");
      chk("midrst.err", 32'(err), 32'(0));
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      chk_outputs("postrst");
    end
    send_frame(16'h00FF, 8'h0C, 8'hF3, 1'b1, 1'b0, 14);
    ack_pulse();
    send_frame(16'h00FF, 8'h0D, 8'hF2, 1'b0, 1'b0, 14);

    // Randomised frames.
    for (int n = 0; n < 40; n++) begin
      cu   = ($urandom_range(3) == 0) ? 16'($urandom) : 16'h00FF;
      d    = 8'($urandom_range(63));
      di   = ~d;
      if ($urandom_range(3) == 0) di = di ^ (8'h01 << $urandom_range(7));
      st   = ($urandom_range(9) != 0);
      ackl = ($urandom_range(3) == 0);
      send_frame(cu, d, di, st, ackl, 14);
      if ($urandom_range(2) == 0) ack_pulse();
    end

    chk("err.pulses", 32'(err_pulses), 32'(m_errs));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
